// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg: shared state enum, opcode constants and default width for the add/sub scheduler
package fp_addsub_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {IDLE, SETTLE, RESPOND} state_t;
endpackage

// File: rtl/fp_rr_arbiter2.sv
// fp_rr_arbiter2: 2-way round-robin grant; pri=0 favours requester 0, pri=1 favours requester 1
module fp_rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic pri,
    output logic grant0,
    output logic grant1
);
    assign grant0 = valid0 & (!valid1 | !pri);
    assign grant1 = valid1 & (!valid0 | pri);
endmodule

// File: rtl/fp_addsub_scheduler.sv
// fp_addsub_scheduler: shares one external FP add/sub datapath between two requesters (IDLE/SETTLE/RESPOND), async reset
module fp_addsub_scheduler
    import fp_addsub_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req0_valid_in,
    output logic                  req0_ready_out,
    input  logic [DATA_WIDTH-1:0] req0_a_in,
    input  logic [DATA_WIDTH-1:0] req0_b_in,
    input  logic                  req0_opcode_in,
    input  logic                  req1_valid_in,
    output logic                  req1_ready_out,
    input  logic [DATA_WIDTH-1:0] req1_a_in,
    input  logic [DATA_WIDTH-1:0] req1_b_in,
    input  logic                  req1_opcode_in,
    output logic                  resp0_valid_out,
    input  logic                  resp0_ready_in,
    output logic                  resp1_valid_out,
    input  logic                  resp1_ready_in,
    output logic [DATA_WIDTH-1:0] resp_data_out,
    output logic [DATA_WIDTH-1:0] dp_floating1_out,
    output logic [DATA_WIDTH-1:0] dp_floating2_out,
    output logic                  dp_opcode_out,
    input  logic [DATA_WIDTH-1:0] dp_result_in,
    output logic                  busy_out
);
    state_t     state;
    logic [3:0] cnt;
    logic       pri;
    logic       gid;
    logic       gnt0;
    logic       gnt1;
    logic       idle;
    fp_rr_arbiter2 u_arb (
        .valid0(req0_valid_in),
        .valid1(req1_valid_in),
        .pri   (pri),
        .grant0(gnt0),
        .grant1(gnt1)
    );
    // readies are masked by reset so every output reads 0 the moment reset asserts
    assign idle           = (state == IDLE) && !rst_in;
    assign req0_ready_out = idle & gnt0;
    assign req1_ready_out = idle & gnt1;
    assign busy_out       = state != IDLE;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= IDLE;
            cnt              <= '0;
            pri              <= 1'b0;
            gid              <= 1'b0;
            resp0_valid_out  <= 1'b0;
            resp1_valid_out  <= 1'b0;
            resp_data_out    <= '0;
            dp_floating1_out <= '0;
            dp_floating2_out <= '0;
            dp_opcode_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready_out | req1_ready_out) begin
                    dp_floating1_out <= gnt1 ? req1_a_in : req0_a_in;
                    dp_floating2_out <= gnt1 ? req1_b_in : req0_b_in;
                    dp_opcode_out    <= gnt1 ? req1_opcode_in : req0_opcode_in;
                    cnt              <= 4'(SETTLE_CYCLES - 1);
                    gid              <= gnt1;
                    state            <= SETTLE;
                end
                SETTLE: if (cnt == 4'd0) begin
                    resp_data_out   <= dp_result_in;
                    resp0_valid_out <= !gid;
                    resp1_valid_out <= gid;
                    state           <= RESPOND;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESPOND: if (gid ? resp1_ready_in : resp0_ready_in) begin
                    resp0_valid_out <= 1'b0;
                    resp1_valid_out <= 1'b0;
                    pri             <= !gid;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// tb_fp_addsub_scheduler: scoreboard bench for the two-requester add/sub scheduler
module tb_fp_addsub_scheduler;
    import fp_addsub_pkg::*;
    localparam int DW = 32;
    localparam int SC = 2;
    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          req0_valid_in, req1_valid_in;
    logic          req0_ready_out, req1_ready_out;
    logic [DW-1:0] req0_a_in, req0_b_in, req1_a_in, req1_b_in;
    logic          req0_opcode_in, req1_opcode_in;
    logic          resp0_valid_out, resp1_valid_out;
    logic          resp0_ready_in, resp1_ready_in;
    logic [DW-1:0] resp_data_out;
    logic [DW-1:0] dp_floating1_out, dp_floating2_out, dp_result_in;
    logic          dp_opcode_out;
    logic          busy_out;
    int            vectors = 0;
    int            miscompares = 0;
    logic [DW:0]   exp_q[$];

    always #5 clk_in = ~clk_in;

    fp_addsub_scheduler #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req0_valid_in(req0_valid_in), .req0_ready_out(req0_ready_out),
        .req0_a_in(req0_a_in), .req0_b_in(req0_b_in), .req0_opcode_in(req0_opcode_in),
        .req1_valid_in(req1_valid_in), .req1_ready_out(req1_ready_out),
        .req1_a_in(req1_a_in), .req1_b_in(req1_b_in), .req1_opcode_in(req1_opcode_in),
        .resp0_valid_out(resp0_valid_out), .resp0_ready_in(resp0_ready_in),
        .resp1_valid_out(resp1_valid_out), .resp1_ready_in(resp1_ready_in),
        .resp_data_out(resp_data_out),
        .dp_floating1_out(dp_floating1_out), .dp_floating2_out(dp_floating2_out),
        .dp_opcode_out(dp_opcode_out), .dp_result_in(dp_result_in),
        .busy_out(busy_out)
    );

    // stand-in datapath: exact for the two IEEE cases, asymmetric scramble otherwise
    function automatic logic [DW-1:0] fp_model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
        if (a == 32'h3F800000 && b == 32'h40000000 && op == OP_ADD) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'h3F800000 && op == OP_SUB) return 32'h40000000;
        return (a + {b[15:0], b[31:16]}) ^ {{(DW-1){1'b0}}, op};
    endfunction

    assign dp_result_in = fp_model(dp_floating1_out, dp_floating2_out, dp_opcode_out);

    function automatic logic rdy(input int id);
        return id != 0 ? req1_ready_out : req0_ready_out;
    endfunction

    function automatic logic rv(input int id);
        return id != 0 ? resp1_valid_out : resp0_valid_out;
    endfunction

    task automatic drive_req(input int id, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
        if (id == 0) begin
            req0_valid_in = v; req0_a_in = a; req0_b_in = b; req0_opcode_in = op;
        end else begin
            req1_valid_in = v; req1_a_in = a; req1_b_in = b; req1_opcode_in = op;
        end
    endtask

    task automatic set_resp_ready(input int id, input logic v);
        if (id == 0) resp0_ready_in = v;
        else resp1_ready_in = v;
    endtask

    // returns one time unit after the accepting edge
    task automatic issue(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op, input bit push);
        int n = 0;
        @(negedge clk_in);
        drive_req(id, 1'b1, a, b, op);
        #1;
        while (!rdy(id) && n < 20) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        vectors++;
        if (!rdy(id)) begin
            miscompares++;
            $display("FAIL issue_timeout req%0d: ready=0, required 1", id);
            drive_req(id, 1'b0, a, b, op);
            return;
        end
        if (push) exp_q.push_back({id[0], fp_model(a, b, op)});
        @(posedge clk_in);
        #1;
        drive_req(id, 1'b0, a, b, op);
        vectors++;
        if ({dp_floating1_out, dp_floating2_out, dp_opcode_out} !== {a, b, op}) begin
            miscompares++;
            $display("FAIL dp_capture req%0d: got %h/%h/%b, required %h/%h/%b", id,
                     dp_floating1_out, dp_floating2_out, dp_opcode_out, a, b, op);
        end
        vectors++;
        if (busy_out !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_accept: got %b, required 1", busy_out);
        end
    endtask

    // waits for the response, checks latency and scoreboard, optionally stalls, then consumes it
    task automatic collect(input int id, input int lat, input int stall);
        int n = 0;
        logic [DW:0] e;
        logic [DW-1:0] held;
        do begin
            @(negedge clk_in);
            n++;
        end while (!rv(id) && n < 20);
        vectors++;
        if (!rv(id) || n != lat) begin
            miscompares++;
            $display("FAIL resp_latency resp%0d: valid=%b after %0d cycles, required 1 after %0d", id, rv(id), n, lat);
        end
        vectors++;
        if (rv(1 - id) !== 1'b0) begin
            miscompares++;
            $display("FAIL resp_other resp%0d: got %b, required 0", 1 - id, rv(1 - id));
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty resp%0d: data=%h, required no response", id, resp_data_out);
        end else begin
            e = exp_q.pop_front();
            if ({id[0], resp_data_out} !== e) begin
                miscompares++;
                $display("FAIL resp_data resp%0d: got %h, required req%0d %h", id, resp_data_out, e[DW], e[DW-1:0]);
            end
        end
        held = resp_data_out;
        for (int i = 0; i < stall; i++) begin
            set_resp_ready(1 - id, 1'b1);
            drive_req(0, 1'b1, 32'hDEAD0000 + i, 32'h0000BEEF, OP_SUB);
            drive_req(1, 1'b1, 32'hCAFE0000 + i, 32'h0000F00D, OP_ADD);
            @(negedge clk_in);
            vectors++;
            if ({rv(id), resp_data_out, busy_out, req0_ready_out, req1_ready_out} !== {1'b1, held, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: valid=%b data=%h busy=%b rdy=%b%b, required 1 %h 1 00",
                         i, rv(id), resp_data_out, busy_out, req1_ready_out, req0_ready_out, held);
            end
        end
        if (stall > 0) begin
            set_resp_ready(1 - id, 1'b0);
            drive_req(0, 1'b0, '0, '0, OP_ADD);
            drive_req(1, 1'b0, '0, '0, OP_ADD);
        end
        set_resp_ready(id, 1'b1);
        @(posedge clk_in);
        #1;
        set_resp_ready(id, 1'b0);
        vectors++;
        if ({rv(id), busy_out} !== 2'b00) begin
            miscompares++;
            $display("FAIL resp_consume resp%0d: valid=%b busy=%b, required 0 0", id, rv(id), busy_out);
        end
    endtask

    function automatic logic [4*DW+5:0] all_outs();
        return {req0_ready_out, req1_ready_out, resp0_valid_out, resp1_valid_out, busy_out, dp_opcode_out,
                resp_data_out, dp_floating1_out, dp_floating2_out, {DW{1'b0}}};
    endfunction

    task automatic test_reset();
        rst_in = 1'b1;
        drive_req(0, 1'b1, 32'h11111111, 32'h22222222, OP_ADD);
        drive_req(1, 1'b0, '0, '0, OP_ADD);
        resp0_ready_in = 1'b0;
        resp1_ready_in = 1'b0;
        #1;
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        @(negedge clk_in);
        drive_req(0, 1'b0, '0, '0, OP_ADD);
        rst_in = 1'b0;
    endtask

    task automatic test_add();
        issue(0, 32'h3F800000, 32'h40000000, OP_ADD, 1'b1);
        collect(0, SC + 1, 0);
    endtask

    task automatic test_sub();
        issue(1, 32'h40400000, 32'h3F800000, OP_SUB, 1'b1);
        collect(1, SC + 1, 0);
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] a0 = 32'h01020304;
        logic [DW-1:0] a1 = 32'hA0B0C0D0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        drive_req(0, 1'b1, a0, 32'h00050006, OP_ADD);
        drive_req(1, 1'b1, a1, 32'h00070008, OP_SUB);
        for (int r = 0; r < 3; r++) begin
            int g = r % 2;
            #1;
            vectors++;
            if ({req0_ready_out, req1_ready_out} !== {g == 0, g == 1}) begin
                miscompares++;
                $display("FAIL rr_grant round %0d: rdy0/rdy1=%b%b, required %b%b", r,
                         req0_ready_out, req1_ready_out, g == 0, g == 1);
            end
            exp_q.push_back(g != 0 ? {1'b1, fp_model(a1, 32'h00070008, OP_SUB)} : {1'b0, fp_model(a0, 32'h00050006, OP_ADD)});
            @(posedge clk_in);
            #1;
            vectors++;
            if (dp_floating1_out !== (g != 0 ? a1 : a0)) begin
                miscompares++;
                $display("FAIL rr_dp round %0d: got %h, required %h", r, dp_floating1_out, g != 0 ? a1 : a0);
            end
            collect(g, SC + 1, 0);
            @(negedge clk_in);
        end
        drive_req(0, 1'b0, '0, '0, OP_ADD);
        drive_req(1, 1'b0, '0, '0, OP_ADD);
    endtask

    task automatic test_stall();
        issue(0, 32'h12345678, 32'h0BADF00D, OP_ADD, 1'b1);
        collect(0, SC + 1, 5);
    endtask

    task automatic test_reset_mid_settle();
        issue(1, 32'h55AA55AA, 32'h00FF00FF, OP_SUB, 1'b0);
        #2;
        rst_in = 1'b1;
        #1;
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_settle: got %h, required 0", all_outs());
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            vectors++;
            if ({resp0_valid_out, resp1_valid_out, busy_out} !== 3'b000) begin
                miscompares++;
                $display("FAIL post_reset_quiet cycle %0d: v0/v1/busy=%b%b%b, required 000", i,
                         resp0_valid_out, resp1_valid_out, busy_out);
            end
        end
        drive_req(0, 1'b1, 32'h1, 32'h2, OP_ADD);
        drive_req(1, 1'b1, 32'h3, 32'h4, OP_ADD);
        #1;
        vectors++;
        if ({req0_ready_out, req1_ready_out} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset_pointer: rdy0/rdy1=%b%b, required 10", req0_ready_out, req1_ready_out);
        end
        drive_req(0, 1'b0, '0, '0, OP_ADD);
        drive_req(1, 1'b0, '0, '0, OP_ADD);
    endtask

    task automatic test_drop_in_settle();
        logic [2*DW:0] held;
        issue(0, 32'h76543210, 32'h01234567, OP_SUB, 1'b1);
        held = {dp_floating1_out, dp_floating2_out, dp_opcode_out};
        @(negedge clk_in);
        drive_req(0, 1'b1, 32'hFFFF0000, 32'h0000FFFF, OP_ADD);
        #1;
        vectors++;
        if (req0_ready_out !== 1'b0) begin
            miscompares++;
            $display("FAIL settle_ready: got %b, required 0", req0_ready_out);
        end
        @(negedge clk_in);
        drive_req(0, 1'b0, '0, '0, OP_ADD);
        collect(0, SC - 1, 0);
        vectors++;
        if ({dp_floating1_out, dp_floating2_out, dp_opcode_out} !== held) begin
            miscompares++;
            $display("FAIL dp_unchanged: got %h, required %h", {dp_floating1_out, dp_floating2_out, dp_opcode_out}, held);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_round_robin();
        test_stall();
        test_reset_mid_settle();
        test_drop_in_settle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fp_addsub_scheduler.md
FP_ADDSUB_SCHEDULER -- requirements
Module: fp_addsub_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, cycles allowed for the combinational add/sub datapath to settle (legal 1..15).
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports reqN_valid_in  input  1  requester N (N=0,1) presents an operation.
REQ-006 SHALL have ports reqN_ready_out  output  1  scheduler accepts requester N's operation this cycle.
REQ-007 SHALL have ports reqN_a_in, reqN_b_in  input  DATA_WIDTH  IEEE-754 operands for requester N.
REQ-008 SHALL have ports reqN_opcode_in  input  1  0 = add, 1 = subtract.
REQ-009 SHALL have ports respN_valid_out  output  1  result ready for requester N.
REQ-010 SHALL have ports respN_ready_in  input  1  requester N consumes the result.
REQ-011 SHALL have port resp_data_out  output  DATA_WIDTH  result, shared by both requesters.
REQ-012 SHALL have ports dp_floating1_out, dp_floating2_out  output  DATA_WIDTH  registered operands driven to the datapath.
REQ-013 SHALL have port dp_opcode_out  output  1  registered opcode driven to the datapath.
REQ-014 SHALL have port dp_result_in  input  DATA_WIDTH  datapath sum/difference.
REQ-015 SHALL have port busy_out  output  1  high in SETTLE or RESPOND.

Function
REQ-016 SHALL implement the FSM states IDLE, SETTLE and RESPOND.
REQ-017 In IDLE the block SHALL assert reqN_ready_out for the granted requester only, combinationally from the valid inputs and the priority pointer.
REQ-018 When both requesters are valid, the grant SHALL go to the requester not served last (round-robin); when one is valid, it SHALL be granted.
REQ-019 On a handshake (valid & ready), the block SHALL register operands and opcode into the dp_* outputs, load the counter with SETTLE_CYCLES-1, latch grant id and go to SETTLE.
REQ-020 In SETTLE the counter SHALL decrement each cycle; at 0 dp_result_in SHALL be registered into resp_data_out and the FSM SHALL go to RESPOND.
REQ-021 Latency: handshake in cycle T SHALL give respN_valid_out high from cycle T+SETTLE_CYCLES+1.
REQ-022 In RESPOND, respN_valid_out SHALL be high only for the latched requester, and resp_data_out SHALL stay stable until respN_ready_in.
REQ-023 On respN_ready_in in RESPOND, the block SHALL go to IDLE and set the priority pointer to favour the other requester.
REQ-024 respN_ready_in for a non-latched requester SHALL be ignored.
REQ-025 No request SHALL be accepted in SETTLE or RESPOND; all reqN_ready_out SHALL be 0.
REQ-026 dp_* outputs SHALL hold their values from one accept until the next accept.
REQ-027 If reqN_valid_in drops before a handshake, nothing SHALL be captured and the pointer SHALL be unchanged.

Reset
REQ-028 Assertion of rst_in SHALL force, immediately: FSM=IDLE, counter=0, pointer favours req0, and all outputs, dp_* and resp_data_out to 0.
REQ-029 A transaction in flight when reset asserts SHALL be discarded with no response issued.

Structure
REQ-030 Package fp_addsub_pkg SHALL hold the FSM state enum, opcode constants (OP_ADD=0, OP_SUB=1) and the default DATA_WIDTH.
REQ-031 The 2-way round-robin grant logic SHALL be sub-module fp_rr_arbiter2.
REQ-032 The floating-point add/sub datapath SHALL be instantiated outside this block and connected through the dp_* ports.

Verification
REQ-033 Test: req0 a=0x3F800000, b=0x40000000, op=0, SETTLE_CYCLES=2 -> resp0_valid_out 3 cycles after the handshake, resp_data_out=0x40400000.
REQ-034 Test: req1 a=0x40400000, b=0x3F800000, op=1 -> resp1_valid_out only, resp_data_out=0x40000000.
REQ-035 Test: both valid in IDLE after reset -> req0 granted first; after its response, req1 granted; then req0 again.
REQ-036 Test: resp0_ready_in held low 5 cycles -> resp_data_out stable, busy_out=1, no new request accepted.
REQ-037 Test: rst_in asserted mid-SETTLE -> all outputs 0 at once; no respN_valid_out after release.
REQ-038 Test: req0 valid one cycle while in SETTLE, then dropped -> no capture; dp_* unchanged.
